// File: rtl/seg7_capture.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus.
// The bus is synchronised, must hold steady for STABLE_CYCLES samples, then the selected digit is updated.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_n,
  input  logic [DIGITS-1:0]   an_n,
  output logic [4*DIGITS-1:0] hex_out,
  output logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   err,
  output logic                upd,
  output logic [IW-1:0]       cap_idx
);
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  logic [6:0]        seg_m, s_seg, p_seg;
  logic [DIGITS-1:0] an_m, s_an, p_an;
  logic [3:0]        nlow;
  logic [IW-1:0]     sel;
  logic              sel_ok, same, fire;
  logic [7:0]        cnt, cnt_nxt;
  logic              cap_vld;
  logic [6:0]        cap_seg;
  logic [IW-1:0]     cap_sel;
  logic              dec_hit;
  logic [3:0]        dec_val;

  // Idle bus (all lines high) is the reset value of every sampling stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1; s_seg <= '1; p_seg <= '1;
      an_m  <= '1; s_an  <= '1; p_an  <= '1;
    end else begin
      seg_m <= seg_n; s_seg <= seg_m; p_seg <= s_seg;
      an_m  <= an_n;  s_an  <= an_m;  p_an  <= s_an;
    end
  end

  always_comb begin
    nlow = '0;
    sel  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an[i]) begin
        nlow = nlow + 4'd1;
        sel  = IW'(i);
      end
    end
    sel_ok = (nlow == 4'd1);
    same   = ({s_seg, s_an} == {p_seg, p_an});
    if (!sel_ok)       cnt_nxt = 8'd0;
    else if (!same)    cnt_nxt = 8'd1;
    else if (cnt == STB) cnt_nxt = STB;
    else               cnt_nxt = cnt + 8'd1;
    fire = (cnt_nxt == STB) && (cnt != STB);
  end

  // Capture is staged one cycle so decode and output update stay off the counter path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cap_vld <= 1'b0;
      cap_seg <= '1;
      cap_sel <= '0;
    end else begin
      cnt     <= cnt_nxt;
      cap_vld <= fire;
      if (fire) begin
        cap_seg <= s_seg;
        cap_sel <= sel;
      end
    end
  end

  always_comb begin
    dec_hit = 1'b1;
    dec_val = 4'h0;
    case (cap_seg)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1011000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out <= '0;
      blank   <= '1;
      err     <= '0;
      upd     <= 1'b0;
      cap_idx <= '0;
    end else begin
      upd <= cap_vld;
      if (cap_vld) cap_idx <= cap_sel;
      for (int d = 0; d < DIGITS; d++) begin
        if (cap_vld && cap_sel == IW'(d)) begin
          if (cap_seg == 7'b1111111) begin
            blank[d] <= 1'b1;
            err[d]   <= 1'b0;
          end else if (dec_hit) begin
            hex_out[4*d +: 4] <= dec_val;
            blank[d]          <= 1'b0;
            err[d]            <= 1'b0;
          end else begin
            err[d] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model feeds a scoreboard; a monitor checks every cycle.
module tb_seg7_capture;
  localparam int DIGITS = 4;
  localparam int STABLE = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] hex_out;
  logic [3:0]  blank, err;
  logic        upd;
  logic [1:0]  cap_idx;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .hex_out(hex_out), .blank(blank), .err(err), .upd(upd), .cap_idx(cap_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          idx;
    logic [15:0] hex;
    logic [3:0]  blk;
    logic [3:0]  er;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a capture happens when a run of identical, single-digit samples reaches STABLE;
  // the result is visible three edges after the sample that completed the run.
  initial begin
    logic [10:0] prev_smp, smp;
    logic [15:0] m_hex;
    logic [3:0]  m_blk, m_err;
    int run, nz, d, hit, nib;
    exp_t e;
    prev_smp = '1; run = 0; m_hex = '0; m_blk = '1; m_err = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        run = 0; prev_smp = '1; m_hex = '0; m_blk = '1; m_err = '0;
      end else begin
        smp = {seg_n, an_n};
        nz = 0; d = 0;
        for (int i = 0; i < DIGITS; i++) if (!an_n[i]) begin nz++; d = i; end
        if (nz == 1 && smp == prev_smp) begin
          if (run < STABLE) begin
            run++;
            if (run == STABLE) begin
              hit = 0; nib = 0;
              for (int n = 0; n < 16; n++) if (tbl[n] == seg_n) begin hit = 1; nib = n; end
              if (seg_n == 7'b1111111) begin
                m_blk[d] = 1'b1; m_err[d] = 1'b0;
              end else if (hit != 0) begin
                m_hex[4*d +: 4] = 4'(nib); m_blk[d] = 1'b0; m_err[d] = 1'b0;
              end else begin
                m_err[d] = 1'b1;
              end
              e.due = cyc + 3; e.idx = d; e.hex = m_hex; e.blk = m_blk; e.er = m_err;
              q.push_back(e);
            end
          end
        end else begin
          run = (nz == 1) ? 1 : 0;
        end
        prev_smp = smp;
      end
    end
  end

  // Monitor: pops on upd, otherwise outputs must hold the last committed state.
  initial begin
    logic [15:0] c_hex;
    logic [3:0]  c_blk, c_err;
    int c_idx;
    exp_t e;
    c_hex = '0; c_blk = '1; c_err = '0; c_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        c_hex = '0; c_blk = '1; c_err = '0; c_idx = 0;
        chk("reset_upd", 32'(upd), 32'd0);
        chk("reset_hex", 32'(hex_out), 32'd0);
        chk("reset_blank", 32'(blank), 32'hF);
        continue;
      end
      if (upd) begin
        if (q.size() == 0) begin
          chk("spurious_upd", 32'(upd), 32'd0);
        end else begin
          e = q.pop_front();
          chk("upd_cycle", 32'(cyc), 32'(e.due));
          c_hex = e.hex; c_blk = e.blk; c_err = e.er; c_idx = e.idx;
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("missing_upd", 32'(upd), 32'd1);
        c_hex = e.hex; c_blk = e.blk; c_err = e.er; c_idx = e.idx;
      end
      chk("hex_out", 32'(hex_out), 32'(c_hex));
      chk("blank", 32'(blank), 32'(c_blk));
      chk("err", 32'(err), 32'(c_err));
      chk("cap_idx", 32'(cap_idx), 32'(c_idx));
    end
  end

  task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seg_n = s;
      an_n  = a;
    end
  endtask

  initial begin
    rst_n = 1'b0; seg_n = '1; an_n = '1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    drive(7'b1111111, 4'b1111, 3);

    drive(7'b0010010, 4'b1110, 20);
    chk("case1_hex0", 32'(hex_out[3:0]), 32'h5);
    chk("case1_blank0", 32'(blank[0]), 32'd0);
    drive(7'b1111111, 4'b1111, 4);

    drive(7'b0110000, 4'b1110, 5);
    drive(7'b1011000, 4'b1110, 12);
    drive(7'b1111111, 4'b1111, 4);
    chk("case2_hex0", 32'(hex_out[3:0]), 32'h7);

    drive(7'b0000000, 4'b1100, 30);
    chk("case3_hex0", 32'(hex_out[3:0]), 32'h7);

    for (int s = 0; s < 2; s++)
      for (int dg = 0; dg < 4; dg++) begin
        logic [3:0] a;
        a = 4'b1111;
        a[dg] = 1'b0;
        drive(tbl[dg + 1], a, 16);
      end
    drive(7'b1111111, 4'b1111, 12);
    chk("scan_hex", 32'(hex_out), 32'h4321);
    chk("scan_blank", 32'(blank), 32'h0);
    chk("scan_err", 32'(err), 32'h0);

    drive(7'b1111111, 4'b1011, 12);
    chk("d2_blank", 32'(blank[2]), 32'd1);
    drive(7'b1111110, 4'b1011, 12);
    chk("d2_err", 32'(err[2]), 32'd1);
    chk("d2_hex_kept", 32'(hex_out[11:8]), 32'h3);
    drive(7'b0000110, 4'b1011, 12);
    chk("d2_hex_e", 32'(hex_out[11:8]), 32'hE);
    chk("d2_err_clr", 32'(err[2]), 32'd0);
    chk("d2_blank_clr", 32'(blank[2]), 32'd0);

    drive(7'b0001000, 4'b1101, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hex_now", 32'(hex_out), 32'h0);
    chk("rst_blank_now", 32'(blank), 32'hF);
    chk("rst_err_now", 32'(err), 32'h0);
    chk("rst_upd_now", 32'(upd), 32'd0);
    chk("rst_idx_now", 32'(cap_idx), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    drive(7'b0001000, 4'b1101, 14);
    chk("rst_recap_a", 32'(hex_out[7:4]), 32'hA);

    for (int k = 0; k < 60; k++) begin
      logic [6:0] s;
      logic [3:0] a;
      int r;
      r = $urandom_range(0, 19);
      if (r < 16) s = tbl[r];
      else if (r < 18) s = 7'b1111111;
      else s = 7'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        a = 4'b1111;
        a[$urandom_range(0, 3)] = 1'b0;
      end else begin
        a = 4'($urandom);
      end
      drive(s, a, $urandom_range(1, 20));
    end
    drive(7'b1111111, 4'b1111, 20);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
